// File: rtl/cr_ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB transfer per AHB transfer, all outputs registered.
// Optional ACCESS-phase timeout abort enabled by defining CR_AHB2APB_TIMEOUT_EN.
module cr_ahb2apb_bridge #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [DATA_W-1:0] hrdata,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
`ifdef CR_AHB2APB_TIMEOUT_EN
   ,
   output logic              timeout_seen
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   state_t state, next_state;
   logic   accept, size_ok, can_accept, to_hit;

   // Elaborates only for unsupported parameter sets, so it shows up in the hierarchy.
   if (DATA_W != 32 || TIMEOUT_CYC < 2) begin : g_unsupported_cfg
   end

   assign accept     = hsel && hready && (htrans inside {2'b10, 2'b11});
   assign size_ok    = (hsize <= 3'd2);
   assign can_accept = (state == S_IDLE) || (state == S_ERR2);

`ifdef CR_AHB2APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   logic [CNT_W-1:0] to_cnt;

   assign to_hit = (state == S_ACCESS) && !pready && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Count is zero on every ACCESS entry because it is held clear outside ACCESS.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt       <= '0;
         timeout_seen <= 1'b0;
      end else begin
         if (state != S_ACCESS)
            to_cnt <= '0;
         else if (!pready)
            to_cnt <= to_cnt + CNT_W'(1);
         if (to_hit)
            timeout_seen <= 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_ERR2: begin
            if (accept) next_state = size_ok ? S_CAPT : S_ERR1;
            else        next_state = S_IDLE;
         end
         S_CAPT:   next_state = S_SETUP;
         S_SETUP:  next_state = S_ACCESS;
         S_ACCESS: begin
            if (pready)      next_state = pslverr ? S_ERR1 : S_IDLE;
            else if (to_hit) next_state = S_ERR1;
         end
         S_ERR1:   next_state = S_ERR2;
         default:  next_state = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hreadyout <= 1'b1;
         hresp     <= 1'b0;
         hrdata    <= '0;
         paddr     <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
      end else begin
         hreadyout <= (next_state == S_IDLE) || (next_state == S_ERR2);
         hresp     <= (next_state == S_ERR1) || (next_state == S_ERR2);
         psel      <= (next_state == S_SETUP) || (next_state == S_ACCESS);
         penable   <= (next_state == S_ACCESS);
         if (can_accept && accept && size_ok) begin
            paddr  <= haddr & ADDR_MASK;
            pwrite <= hwrite;
         end
         if (state == S_CAPT)
            pwdata <= hwdata;
         if (state == S_ACCESS && pready && !pslverr && !pwrite)
            hrdata <= prdata;
      end
   end

endmodule

// File: tb/tb_cr_ahb2apb_bridge.sv
// Bench for cr_ahb2apb_bridge: per-transfer cycle schedule model, random traffic, one compare process.
// Define CR_AHB2APB_TIMEOUT_EN for both files to exercise the timeout abort (TIMEOUT_CYC=4 here).
module tb_cr_ahb2apb_bridge;

`ifdef CR_AHB2APB_TIMEOUT_EN
   localparam int TO_LIMIT = 4;
`else
   localparam int TO_LIMIT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel, hwrite, hready, pready, pslverr;
   logic [31:0] haddr, hwdata, prdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hreadyout, hresp, psel, penable, pwrite;
   logic [31:0] hrdata, paddr, pwdata;
`ifdef CR_AHB2APB_TIMEOUT_EN
   logic        timeout_seen;
`endif

   always #5 clk = ~clk;

   cr_ahb2apb_bridge #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO_LIMIT == 0 ? 256 : TO_LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
      .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
      .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
`ifdef CR_AHB2APB_TIMEOUT_EN
      , .timeout_seen(timeout_seen)
`endif
   );

   // Expected DUT outputs for one cycle; APB address/data fields checked only when apb is set.
   typedef struct {
      logic        hrdy, hresp, psel, pen, apb, pwrite, tos;
      logic [31:0] paddr, pwdata, hrdata;
   } exp_t;

   exp_t        exp_q[$];
   int          nvec = 0;
   int          nerr = 0;
   int          cyc  = 0;
   logic [31:0] m_hrdata = '0, m_paddr = '0, m_pwdata = '0;
   logic        m_pwrite = 1'b0, m_tos = 1'b0;

   task automatic chk1(input string name, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic hrdy, input logic hr, input logic ps, input logic pe);
      exp_t e;
      e.hrdy = hrdy; e.hresp = hr; e.psel = ps; e.pen = pe; e.apb = ps;
      e.paddr = m_paddr; e.pwrite = m_pwrite; e.pwdata = m_pwdata;
      e.hrdata = m_hrdata; e.tos = m_tos;
      return e;
   endfunction

   // Queue the expectation for the cycle after the coming edge, then move to the next negedge.
   task automatic step(input exp_t e);
      exp_q.push_back(e);
      cyc++;
      @(negedge clk);
   endtask

   // Random bus noise that must not start a transfer (hready low) and random APB slave noise.
   task automatic junk();
      hsel    = 1'($urandom_range(0, 1));
      htrans  = 2'($urandom_range(0, 3));
      haddr   = $urandom;
      hwrite  = 1'($urandom_range(0, 1));
      hsize   = 3'($urandom_range(0, 7));
      hwdata  = $urandom;
      hready  = 1'b0;
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
   endtask

   task automatic gap();
      junk();
      case ($urandom_range(0, 2))
         0:       begin hsel = 1'b0; hready = 1'($urandom_range(0, 1)); end
         1:       begin hsel = 1'b1; hready = 1'b1; htrans = 2'($urandom_range(0, 1)); end
         default: begin hsel = 1'b1; hready = 1'b0; htrans = 2'($urandom_range(2, 3)); end
      endcase
      step(mk(1'b1, 1'b0, 1'b0, 1'b0));
   endtask

   // One AHB transfer from its address phase to the cycle where hreadyout returns high.
   task automatic txn(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int w,
                      input logic err, output int lat);
      int t0;
      t0 = cyc;
      junk();
      hsel = 1'b1; hready = 1'b1; htrans = 2'($urandom_range(2, 3));
      haddr = addr; hwrite = wr; hsize = size;
      if (size > 3'd2) begin
         step(mk(1'b0, 1'b1, 1'b0, 1'b0));
         junk();
         step(mk(1'b1, 1'b1, 1'b0, 1'b0));
         lat = cyc - t0;
         return;
      end
      m_paddr = addr & 32'hFFFF_FFFC; m_pwrite = wr; m_pwdata = wdata;
      step(mk(1'b0, 1'b0, 1'b0, 1'b0));
      junk(); hwdata = wdata;
      step(mk(1'b0, 1'b0, 1'b1, 1'b0));
      junk();
      step(mk(1'b0, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i <= w; i++) begin
         junk();
         if (i == w) begin
            pready = 1'b1; pslverr = err; prdata = rdata;
            if (err) begin
               step(mk(1'b0, 1'b1, 1'b0, 1'b0));
               junk();
               step(mk(1'b1, 1'b1, 1'b0, 1'b0));
            end else begin
               if (!wr) m_hrdata = rdata;
               step(mk(1'b1, 1'b0, 1'b0, 1'b0));
            end
            break;
         end
         pready = 1'b0;
         if (TO_LIMIT != 0 && i == TO_LIMIT - 1) begin
            m_tos = 1'b1;
            step(mk(1'b0, 1'b1, 1'b0, 1'b0));
            junk(); pready = 1'b1;
            step(mk(1'b1, 1'b1, 1'b0, 1'b0));
            break;
         end
         step(mk(1'b0, 1'b0, 1'b1, 1'b1));
      end
      lat = cyc - t0;
   endtask

   // Start a write, pull reset during its first ACCESS cycle, then release.
   task automatic rst_mid();
      exp_t e;
      junk();
      hsel = 1'b1; hready = 1'b1; htrans = 2'b10; haddr = $urandom; hwrite = 1'b1; hsize = 3'd2;
      m_paddr = haddr & 32'hFFFF_FFFC; m_pwrite = 1'b1; m_pwdata = $urandom;
      step(mk(1'b0, 1'b0, 1'b0, 1'b0));
      junk(); hwdata = m_pwdata;
      step(mk(1'b0, 1'b0, 1'b1, 1'b0));
      junk();
      step(mk(1'b0, 1'b0, 1'b1, 1'b1));
      junk();
      rst_n = 1'b0;
      m_hrdata = '0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_tos = 1'b0;
      e = mk(1'b1, 1'b0, 1'b0, 1'b0);
      e.apb = 1'b1;
      step(e);
      rst_n = 1'b1;
      gap();
   endtask

   initial begin : compare
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk1("hreadyout", hreadyout, e.hrdy);
            chk1("hresp", hresp, e.hresp);
            chk1("psel", psel, e.psel);
            chk1("penable", penable, e.pen);
            chk32("hrdata", hrdata, e.hrdata);
            if (e.apb) begin
               chk32("paddr", paddr, e.paddr);
               chk1("pwrite", pwrite, e.pwrite);
               chk32("pwdata", pwdata, e.pwdata);
            end
`ifdef CR_AHB2APB_TIMEOUT_EN
            chk1("timeout_seen", timeout_seen, e.tos);
`endif
         end
      end
   end

   initial begin : driver
      exp_t        e;
      int          lat;
      logic [2:0]  sz;
      rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
      hwdata = '0; hready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      @(negedge clk);
      e = mk(1'b1, 1'b0, 1'b0, 1'b0);
      e.apb = 1'b1;
      step(e);
      step(e);
      rst_n = 1'b1;
      gap();

      txn(32'h0000_1006, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, lat);
      chk32("pin_wr_latency", lat, 4);
      chk32("pin_wr_paddr", m_paddr, 32'h0000_1004);
      gap();
      txn(32'h0000_0020, 1'b0, 3'd2, 32'h0, 32'h1234_5678, 2, 1'b0, lat);
      chk32("pin_rd_latency", lat, 6);
      chk32("pin_rd_hrdata", hrdata, 32'h1234_5678);
      txn(32'h0000_0040, 1'b1, 3'd1, 32'h5555_AAAA, 32'h0, 0, 1'b1, lat);
      chk32("pin_err_latency", lat, 5);
      chk1("pin_err_hresp", hresp, 1'b1);
      gap();
      txn(32'h0000_0044, 1'b0, 3'd3, 32'h0, 32'h0, 0, 1'b0, lat);
      chk32("pin_size_latency", lat, 2);
      gap();
      txn(32'h0000_0100, 1'b1, 3'd2, 32'h0BAD_F00D, 32'h0, 0, 1'b0, lat);
      txn(32'h0000_0104, 1'b0, 3'd0, 32'h0, 32'hCAFE_F00D, 0, 1'b0, lat);
      chk32("pin_b2b_hrdata", hrdata, 32'hCAFE_F00D);
`ifdef CR_AHB2APB_TIMEOUT_EN
      gap();
      txn(32'h0000_0200, 1'b1, 3'd2, 32'h0, 32'h0, 10, 1'b0, lat);
      chk32("pin_timeout_latency", lat, 8);
      chk1("pin_timeout_seen", timeout_seen, 1'b1);
`endif
      rst_mid();

      for (int n = 0; n < 250; n++) begin
         int ngap;
         ngap = $urandom_range(0, 2);
         for (int g = 0; g < ngap; g++) gap();
         if ($urandom_range(0, 39) == 0) begin
            rst_mid();
         end else begin
            sz = ($urandom_range(0, 9) >= 8) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            txn($urandom, 1'($urandom_range(0, 1)), sz, $urandom, $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 4) == 0), lat);
         end
      end
      gap();

      @(posedge clk);
      #3;
      chk32("queue_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin : watchdog
      #500000;
      nerr++;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
